// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, one-word hold buffer, redirect and halt handling.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count_o (saturating count of valid IF/ID loads).
//
// state  | meaning
// FETCH  | requesting imem at pc, loading IF/ID when the word returns
// HOLD   | word captured while decode stalls; no request until released
// DROP   | redirected with a request in flight; wait for it and discard the word
// HALTED | frozen after HALT; only reset leaves
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    input  logic        halt_i,
    output logic [15:0] instr_o,
    output logic [4:0]  opcode_o,
    output logic [15:0] pc_plus2_o,
    output logic        valid_o,
    output logic        halted_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_count_o
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_DROP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] drop_addr_q, drop_addr_d;
    logic        started_q, started_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [15:0] hold_pc2_q, hold_pc2_d;
    logic        got;
    logic [15:0] pc_inc;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        started_d    = 1'b1;
        instr_d      = instr_q;
        pc2_d        = pc2_q;
        valid_d      = valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc2_d   = hold_pc2_q;
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        pc_inc       = pc_q + 16'd2;

        // No request in the first cycle after reset, so a stale response is never consumed.
        case (state_q)
            S_FETCH: imem_req = started_q;
            S_DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
            end
            default: ;
        endcase
        got = imem_req & imem_ready;

        if (state_q != S_HALTED) begin
            if (redirect_i) begin
                pc_d         = {redirect_pc_i[15:1], 1'b0};
                instr_d      = NOP_INSTR;
                valid_d      = 1'b0;
                hold_instr_d = 16'h0000;
                hold_pc2_d   = 16'h0000;
                if (imem_req && !imem_ready) begin
                    state_d = S_DROP;
                    if (state_q == S_FETCH) drop_addr_d = pc_q;
                end else begin
                    state_d = S_FETCH;
                end
            end else if (halt_i) begin
                state_d = S_HALTED;
            end else begin
                case (state_q)
                    S_FETCH: begin
                        if (got && !stall_i) begin
                            instr_d = imem_rdata;
                            pc2_d   = pc_inc;
                            valid_d = 1'b1;
                            pc_d    = pc_inc;
                        end else if (got) begin
                            hold_instr_d = imem_rdata;
                            hold_pc2_d   = pc_inc;
                            pc_d         = pc_inc;
                            state_d      = S_HOLD;
                        end else if (!stall_i) begin
                            valid_d = 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (!stall_i) begin
                            instr_d = hold_instr_q;
                            pc2_d   = hold_pc2_q;
                            valid_d = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    S_DROP: begin
                        if (imem_ready) state_d = S_FETCH;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            started_q    <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc2_q        <= 16'h0000;
            valid_q      <= 1'b0;
            hold_instr_q <= 16'h0000;
            hold_pc2_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            started_q    <= started_d;
            instr_q      <= instr_d;
            pc2_q        <= pc2_d;
            valid_q      <= valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc2_q   <= hold_pc2_d;
        end
    end

    assign instr_o    = instr_q;
    assign opcode_o   = instr_q[15:11];
    assign pc_plus2_o = pc2_q;
    assign valid_o    = valid_q;
    assign halted_o   = (state_q == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count_q, fetch_count_d;
    logic        load_valid;

    always_comb begin
        load_valid = (state_q != S_HALTED) && !redirect_i && !halt_i && !stall_i &&
                     (((state_q == S_FETCH) && imem_req && imem_ready) || (state_q == S_HOLD));
        fetch_count_d = fetch_count_q;
        if (load_valid && (fetch_count_q != 16'hFFFF)) fetch_count_d = fetch_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_count_q <= 16'h0000;
        else        fetch_count_q <= fetch_count_d;
    end

    assign fetch_count_o = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based behavioural model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_fetch_stage;
    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        halt_i;
    logic [15:0] instr_o;
    logic [4:0]  opcode_o;
    logic [15:0] pc_plus2_o;
    logic        valid_o;
    logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count_o;
`endif

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .halt_i       (halt_i),
        .instr_o      (instr_o),
        .opcode_o     (opcode_o),
        .pc_plus2_o   (pc_plus2_o),
        .valid_o      (valid_o),
        .halted_o     (halted_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count_o(fetch_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: program counter, IF/ID contents, a queue for the held word, and the
    // address of an in-flight request that must be discarded (-1 when none).
    logic [15:0] m_pc, m_instr, m_pc2;
    bit          m_valid, m_halted, m_gap;
    logic [31:0] m_buf[$];
    int          m_discard;
    int          m_count;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    function automatic bit m_req();
        return !m_halted && !m_gap && (m_discard >= 0 || m_buf.size() == 0);
    endfunction

    function automatic logic [15:0] m_addr();
        return (m_discard >= 0) ? m_discard[15:0] : m_pc;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = NOP; m_pc2 = 16'h0000;
        m_valid = 0; m_halted = 0; m_gap = 1;
        m_buf.delete(); m_discard = -1; m_count = 0;
    endtask

    task automatic bump();
        if (m_count < 65535) m_count++;
    endtask

    task automatic model_update(input bit rdy, input bit stl, input bit rd,
                                input logic [15:0] rpc, input bit hlt);
        bit req;
        logic [15:0] a;
        req = m_req();
        a   = m_addr();
        if (!m_halted) begin
            if (rd) begin
                m_pc = {rpc[15:1], 1'b0};
                m_instr = NOP; m_valid = 0; m_buf.delete();
                if (req && !rdy) begin
                    if (m_discard < 0) m_discard = int'(a);
                end else begin
                    m_discard = -1;
                end
            end else if (hlt) begin
                m_halted = 1;
            end else if (m_discard >= 0) begin
                if (rdy) m_discard = -1;
            end else if (m_buf.size() > 0) begin
                if (!stl) begin
                    {m_instr, m_pc2} = m_buf.pop_front();
                    m_valid = 1; bump();
                end
            end else if (req && rdy) begin
                if (!stl) begin
                    m_instr = memf(m_pc); m_pc2 = m_pc + 16'd2; m_valid = 1; bump();
                end else begin
                    m_buf.push_back({memf(m_pc), 16'(m_pc + 16'd2)});
                end
                m_pc = m_pc + 16'd2;
            end else if (!stl) begin
                m_valid = 0;
            end
        end
        m_gap = 0;
    endtask

    task automatic compare_all();
        chk1("req", imem_req, m_req());
        if (m_req()) chk("addr", imem_addr, m_addr());
        chk("instr", instr_o, m_instr);
        chk("opcode", {11'b0, opcode_o}, {11'b0, m_instr[15:11]});
        if (m_valid) chk("pc_plus2", pc_plus2_o, m_pc2);
        chk1("valid", valid_o, m_valid);
        chk1("halted", halted_o, m_halted);
`ifdef FETCH_PERF_CNT_EN
        chk("count", fetch_count_o, m_count[15:0]);
`endif
    endtask

    task automatic step(input bit rdy, input bit stl, input bit rd,
                        input logic [15:0] rpc, input bit hlt);
        @(negedge clk);
        imem_ready = rdy; stall_i = stl; redirect_i = rd; redirect_pc_i = rpc; halt_i = hlt;
        imem_rdata = memf(imem_addr);
        #1 compare_all();
        @(posedge clk);
        model_update(rdy, stl, rd, rpc, hlt);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk1({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_addr"}, imem_addr, 16'h0000);
        chk({tag, "_instr"}, instr_o, NOP);
        chk({tag, "_pc2"}, pc_plus2_o, 16'h0000);
        chk1({tag, "_valid"}, valid_o, 1'b0);
        chk1({tag, "_halted"}, halted_o, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_count"}, fetch_count_o, 16'h0000);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_values("rst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 0; imem_rdata = 0; stall_i = 0;
        redirect_i = 0; redirect_pc_i = 0; halt_i = 0;
        model_reset();
        do_reset();

        // Streaming with ready tied high
        for (int k = 1; k <= 9; k++) begin
            step(1, 0, 0, 16'h0, 0);
            if (k == 2) begin
                chk("a_first_instr", instr_o, 16'hC3A5);
                chk("a_first_pc2", pc_plus2_o, 16'h0002);
                chk1("a_first_valid", valid_o, 1'b1);
            end
        end
        chk("a_instr_0e", instr_o, 16'hC3AB);
        chk("a_addr_10", imem_addr, 16'h0010);

        // Three-cycle stall at pc 0x0010
        step(1, 1, 0, 16'h0, 0);
        chk1("b_hold_req", imem_req, 1'b0);
        step(1, 1, 0, 16'h0, 0);
        step(1, 1, 0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 0);
        chk("b_release_instr", instr_o, 16'hC3B5);
        chk("b_next_addr", imem_addr, 16'h0012);
        step(1, 0, 0, 16'h0, 0);
        chk("b_next_instr", instr_o, 16'hC3B7);

        // Redirect while the request at 0x0014 waits
        step(0, 0, 0, 16'h0, 0);
        step(0, 0, 1, 16'h0041, 0);
        chk("c_drop_addr", imem_addr, 16'h0014);
        chk1("c_flush_valid", valid_o, 1'b0);
        step(1, 0, 0, 16'h0, 0);
        chk("c_new_addr", imem_addr, 16'h0040);
        chk1("c_after_drop_valid", valid_o, 1'b0);

        // Redirect beats halt, then halt alone
        step(1, 0, 1, 16'h0100, 1);
        chk1("d_no_halt", halted_o, 1'b0);
        chk("d_addr_100", imem_addr, 16'h0100);
        step(1, 0, 0, 16'h0, 0);
        chk("d_instr_100", instr_o, 16'hC2A5);
        step(1, 0, 0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 1);
        for (int k = 0; k < 4; k++) step(1, k[0], 1, 16'h0300, 0);
        chk1("d_halted", halted_o, 1'b1);
        chk1("d_halted_req", imem_req, 1'b0);
        chk("d_frozen_instr", instr_o, 16'hC2A1);

        // PC wrap and redirect during DROP
        do_reset();
        step(1, 0, 1, 16'hFFFF, 0);
        step(1, 0, 0, 16'h0, 0);
        chk("e_wrap_instr", instr_o, 16'h3C5B);
        chk("e_wrap_pc2", pc_plus2_o, 16'h0000);
        chk("e_wrap_addr", imem_addr, 16'h0000);
        step(0, 0, 0, 16'h0, 0);
        step(0, 0, 1, 16'h0500, 0);
        step(0, 0, 1, 16'h0601, 0);
        chk("e_drop_hold_addr", imem_addr, 16'h0000);
        step(1, 0, 0, 16'h0, 0);
        chk("e_second_target", imem_addr, 16'h0600);

        // Mixed pattern of ready/stall/redirect
        for (int i = 0; i < 40; i++)
            step((i % 3) != 1, (i % 5) == 2, (i % 11) == 4, 16'(16'h0200 + i * 7), 0);

        // Async reset in the middle of a DROP
        step(1, 0, 0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 0);
        step(0, 0, 0, 16'h0, 0);
        step(0, 0, 1, 16'h0700, 0);
        chk1("f_drop_req", imem_req, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("f_async");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) step(1, 0, 0, 16'h0, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("f_count5", fetch_count_o, 16'd5);
`endif
        chk("f_instr_8", instr_o, memf(16'h0008));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 16-bit core.
- Owns the PC, issues requests to instruction memory with a req/ready handshake, and buffers one returned word when decode stalls.
- Presents the instruction, its opcode field and PC+2 to the decode/control stage.
- Handles redirects for branch/jump (PcSel path) and freezes on HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0800, encoding injected into IF/ID on flush or reset (opcode 00001).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
imem_req  out  1  instruction-memory request valid.
imem_addr  out  16  fetch address; held stable while imem_req=1 and imem_ready=0.
imem_ready  in  1  memory returns imem_rdata this cycle; meaningful only when imem_req=1.
imem_rdata  in  16  fetched instruction word.
stall_i  in  1  decode cannot accept; IF/ID holds.
redirect_i  in  1  taken branch/jump from execute.
redirect_pc_i  in  16  redirect target; bit 0 ignored (forced 0).
halt_i  in  1  decode has a valid HALT in ID.
instr_o  out  16  IF/ID instruction.
opcode_o  out  5  instr_o[15:11], to control decoder.
pc_plus2_o  out  16  IF/ID PC+2 of instr_o (used for JAL/JALR link and branch base).
valid_o  out  1  IF/ID holds a real instruction.
halted_o  out  1  stage is in HALTED.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC, instr_o=NOP_INSTR, pc_plus2_o=0, valid_o=0, hold buffer empty, halted_o=0. imem_req rises 1 cycle after rst_n deasserts.
- States: FETCH, HOLD, DROP, HALTED.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready with stall_i=0: IF/ID <= {imem_rdata, pc+2}, valid_o=1, pc <= pc+2. Next request issues the following cycle (1 instruction per cycle when ready is always 1).
  - On imem_ready with stall_i=1: capture word and pc+2 in hold buffer, pc <= pc+2, go HOLD.
  - No ready and stall_i=0: valid_o <= 0 (bubble).
  - No ready and stall_i=1: IF/ID unchanged.
- HOLD:
  - imem_req=0; IF/ID unchanged while stall_i=1.
  - When stall_i=0: IF/ID <= hold buffer, valid_o=1, go FETCH.
- PC arithmetic is 16-bit modulo; 16'hFFFE+2 = 16'h0000, with no flag.
- Redirect (highest priority; older than halt):
  - pc <= {redirect_pc_i[15:1],1'b0}; IF/ID <= NOP_INSTR with valid_o=0 next cycle regardless of stall_i; hold buffer cleared.
  - If a request is outstanding (imem_req=1, imem_ready=0) the address must stay stable: go DROP. Otherwise go FETCH, with the new address issued the next cycle.
  - A redirect arriving in the same cycle as imem_ready discards that word and goes to FETCH.
- DROP:
  - imem_req=1 with the old address until imem_ready; the returned word is discarded; then go FETCH.
  - A further redirect during DROP only updates pc.
- Halt:
  - halt_i=1 with redirect_i=0: go HALTED from any state.
  - imem_req=0, IF/ID frozen (valid_o keeps its value so the HALT stays visible), halted_o=1.
  - An outstanding request is abandoned; memory must tolerate req dropping.
  - HALTED exits only by reset.
  - halt_i with redirect_i in the same cycle: the redirect wins and halt is ignored.
- Reset mid-transaction: all state cleared immediately; no memory response is consumed until a new req is issued.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output fetch_count_o[15:0]. Reset 0; increments by 1 on every cycle a word is written into IF/ID with valid_o=1, including transfers from HOLD; saturates at 16'hFFFF; freezes in HALTED.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Reset release, imem_ready tied 1, rdata=addr-derived -> imem_addr 0,2,4,... on consecutive cycles; valid_o=1 from cycle 2; pc_plus2_o = addr+2.
- stall_i=1 for 3 cycles while ready=1 at pc=0x0010 -> one word held, imem_req=0 during HOLD; after release instr_o=mem[0x0010], next addr 0x0012, no word lost or duplicated.
- ready delayed 2 cycles, redirect_i to 0x0041 during wait -> imem_addr stays at old value until ready, old word discarded, next addr 0x0040, valid_o=0 for the flush cycle.
- halt_i and redirect_i both high, target 0x0100 -> no halt, fetch resumes at 0x0100; halt_i alone later -> halted_o=1, imem_req=0 permanently until rst_n low.
- pc=0xFFFE fetch -> next imem_addr 0x0000, pc_plus2_o=0x0000.
- rst_n pulsed low mid-DROP -> outputs return to reset values asynchronously; with FETCH_PERF_CNT_EN defined, fetch_count_o=0 and counts 5 after 5 accepted fetches.
